// File: rtl/car_control_pkg.sv
// Shared game constants and the run/pause state type used by the car, player
// and renderer blocks.
package car_control_pkg;

  localparam int H_DISPLAY     = 640;
  localparam int V_DISPLAY     = 480;
  localparam int CAR_WIDTH     = 32;
  localparam int CAR_HEIGHT    = 16;
  localparam int CAR_Y1        = 96;
  localparam int CAR_Y2        = 176;
  localparam int CAR_Y3        = 256;
  localparam int CAR_Y4        = 336;
  localparam int PLAYER_WIDTH  = 16;
  localparam int PLAYER_HEIGHT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } game_state_t;

endpackage

// File: rtl/car_control_lane.sv
// One car lane: a level-scaled period divider that moves the car one STEP
// per period in a fixed direction, wrapping at the screen edge.
module car_lane #(
  parameter bit          DIR         = 1'b0,
  parameter int unsigned LANE_PERIOD = 1_000_000,
  parameter int unsigned INIT_X      = 0,
  parameter int unsigned STEP        = 8,
  parameter int unsigned H_DISPLAY   = 640
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] level,
  output logic [9:0] x
);

  localparam int          CW     = $clog2(LANE_PERIOD + 1);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] H_W    = 11'(H_DISPLAY);

  logic [CW-1:0] cnt;
  logic [31:0]   period;
  logic          tick;
  logic [10:0]   x_ext;
  logic [10:0]   x_nxt;

  // Halving per level, but never faster than one move every two cycles.
  always_comb begin
    period = 32'(LANE_PERIOD) >> level;
    if (period < 32'd2) period = 32'd2;
  end

  assign tick  = enable && !clear && (32'(cnt) >= period - 32'd1);
  assign x_ext = {1'b0, x};

  always_comb begin
    x_nxt = x_ext;
    if (!DIR) begin
      if (x_ext + STEP_W >= H_W) x_nxt = x_ext + STEP_W - H_W;
      else                       x_nxt = x_ext + STEP_W;
    end else begin
      if (x_ext < STEP_W) x_nxt = x_ext + H_W - STEP_W;
      else                x_nxt = x_ext - STEP_W;
    end
  end

  // clear wins over a pending tick so a level change never moves the car.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      x   <= 10'(INIT_X);
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt <= '0;
        x   <= x_nxt[9:0];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/car_control.sv
// Four-lane car position generator with a run/pause FSM and a saturating
// level counter that speeds every lane up.
module car_control #(
  parameter int unsigned H_DISPLAY    = car_control_pkg::H_DISPLAY,
  parameter int unsigned STEP         = 8,
  parameter int unsigned LANE_PERIOD1 = 1_000_000,
  parameter int unsigned LANE_PERIOD2 = 800_000,
  parameter int unsigned LANE_PERIOD3 = 600_000,
  parameter int unsigned LANE_PERIOD4 = 400_000,
  parameter int unsigned INIT_X1      = 0,
  parameter int unsigned INIT_X2      = 160,
  parameter int unsigned INIT_X3      = 320,
  parameter int unsigned INIT_X4      = 480,
  parameter int unsigned MAX_LEVEL    = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         level_up,
  output logic [9:0]                   car_x1,
  output logic [9:0]                   car_x2,
  output logic [9:0]                   car_x3,
  output logic [9:0]                   car_x4,
  output logic [1:0]                   level,
  output logic                         running,
  output car_control_pkg::game_state_t dbg_state
);

  car_control_pkg::game_state_t state, state_nxt;
  logic level_ok;
  logic lane_en;

  // level_up is only meaningful once a game is under way.
  assign level_ok  = level_up && (state != car_control_pkg::IDLE);
  assign lane_en   = (state == car_control_pkg::RUN);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      car_control_pkg::IDLE:   if (start)  state_nxt = car_control_pkg::RUN;
      car_control_pkg::RUN:    if (pause)  state_nxt = car_control_pkg::PAUSED;
      car_control_pkg::PAUSED: if (!pause) state_nxt = car_control_pkg::RUN;
      default:                 state_nxt = car_control_pkg::IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= car_control_pkg::IDLE;
      running <= 1'b0;
      level   <= 2'd0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == car_control_pkg::RUN);
      if (level_ok && (level < 2'(MAX_LEVEL))) level <= level + 2'd1;
    end
  end

  car_lane #(.DIR(1'b0), .LANE_PERIOD(LANE_PERIOD1), .INIT_X(INIT_X1),
             .STEP(STEP), .H_DISPLAY(H_DISPLAY)) u_lane1 (
    .CLK(CLK), .RST(RST), .enable(lane_en), .clear(level_ok), .level(level), .x(car_x1));
  car_lane #(.DIR(1'b1), .LANE_PERIOD(LANE_PERIOD2), .INIT_X(INIT_X2),
             .STEP(STEP), .H_DISPLAY(H_DISPLAY)) u_lane2 (
    .CLK(CLK), .RST(RST), .enable(lane_en), .clear(level_ok), .level(level), .x(car_x2));
  car_lane #(.DIR(1'b0), .LANE_PERIOD(LANE_PERIOD3), .INIT_X(INIT_X3),
             .STEP(STEP), .H_DISPLAY(H_DISPLAY)) u_lane3 (
    .CLK(CLK), .RST(RST), .enable(lane_en), .clear(level_ok), .level(level), .x(car_x3));
  car_lane #(.DIR(1'b1), .LANE_PERIOD(LANE_PERIOD4), .INIT_X(INIT_X4),
             .STEP(STEP), .H_DISPLAY(H_DISPLAY)) u_lane4 (
    .CLK(CLK), .RST(RST), .enable(lane_en), .clear(level_ok), .level(level), .x(car_x4));

endmodule

// File: tb/tb_car_control.sv
// Bench for car_control: directed scenarios plus a randomized run, all
// checked against a move-count model of the lanes.
module tb_car_control;
  import car_control_pkg::*;

  localparam int P    [4] = '{8, 16, 12, 20};
  localparam int INIT [4] = '{0, 160, 320, 480};
  localparam int DIRS [4] = '{0, 1, 0, 1};

  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, pause = 1'b0, level_up = 1'b0;
  logic [9:0] car_x1, car_x2, car_x3, car_x4, w_x1, w_x2, w_x3, w_x4;
  logic [1:0] level, w_level;
  logic running, w_running;
  game_state_t dbg_state, w_state;
  logic [44:0] dut_vec;

  int checks = 0, failures = 0;
  game_state_t m_state;
  int m_level;
  int m_acc[4];
  int m_moves[4];
  logic [9:0] exp_q[$];

  always #5 CLK = ~CLK;

  car_control #(.STEP(8), .LANE_PERIOD1(8), .LANE_PERIOD2(16), .LANE_PERIOD3(12),
                .LANE_PERIOD4(20), .INIT_X1(0), .INIT_X2(160), .INIT_X3(320),
                .INIT_X4(480)) dut (
    .CLK(CLK), .RST(RST), .start(start), .pause(pause), .level_up(level_up),
    .car_x1(car_x1), .car_x2(car_x2), .car_x3(car_x3), .car_x4(car_x4),
    .level(level), .running(running), .dbg_state(dbg_state));

  car_control #(.STEP(8), .LANE_PERIOD1(8), .LANE_PERIOD2(16), .LANE_PERIOD3(12),
                .LANE_PERIOD4(20), .INIT_X1(632), .INIT_X2(4), .INIT_X3(320),
                .INIT_X4(480)) dut_w (
    .CLK(CLK), .RST(RST), .start(start), .pause(pause), .level_up(level_up),
    .car_x1(w_x1), .car_x2(w_x2), .car_x3(w_x3), .car_x4(w_x4),
    .level(w_level), .running(w_running), .dbg_state(w_state));

  assign dut_vec = {car_x1, car_x2, car_x3, car_x4, level, running, dbg_state};

  function automatic int period_of(int lane, int lvl);
    int p;
    p = P[lane] >> lvl;
    return (p < 2) ? 2 : p;
  endfunction

  // Position is just the start point plus signed distance travelled, modulo width.
  function automatic int exp_x(int lane);
    int d;
    d = (m_moves[lane] * 8) % 640;
    if (DIRS[lane] == 0) return (INIT[lane] + d) % 640;
    return (INIT[lane] - d + 640) % 640;
  endfunction

  function automatic logic [44:0] exp_vec();
    return {10'(exp_x(0)), 10'(exp_x(1)), 10'(exp_x(2)), 10'(exp_x(3)),
            2'(m_level), (m_state == RUN), m_state};
  endfunction

  task automatic model_reset();
    m_state = IDLE;
    m_level = 0;
    for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_moves[i] = 0; end
  endtask

  task automatic tick();
    bit lu_ok;
    @(posedge CLK);
    lu_ok = level_up && (m_state != IDLE);
    for (int i = 0; i < 4; i++) begin
      if (lu_ok) m_acc[i] = 0;
      else if (m_state == RUN) begin
        m_acc[i]++;
        if (m_acc[i] == period_of(i, m_level)) begin m_acc[i] = 0; m_moves[i]++; end
      end
    end
    if (lu_ok && m_level < 3) m_level++;
    case (m_state)
      IDLE:    if (start)  m_state = RUN;
      RUN:     if (pause)  m_state = PAUSED;
      default: if (!pause) m_state = RUN;
    endcase
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; start = 1'b0; pause = 1'b0; level_up = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic enter_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      tick();
      checks++;
      if ({car_x1, car_x2, car_x3, car_x4, level, running} !== {10'd0, 10'd160, 10'd320, 10'd480, 2'd0, 1'b0}) begin
        failures++; $display("FAIL idle_hold c=%0d: got %h expected %h", c, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_first_move();
    do_reset();
    enter_run();
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL first_move_model c=%0d: got %h expected %h", c, dut_vec, exp_vec()); end
      if (c == 7)  begin checks++; if (car_x1 !== 10'd0)   begin failures++; $display("FAIL x1_early: got %0d expected 0", car_x1); end end
      if (c == 8)  begin checks++; if (car_x1 !== 10'd8)   begin failures++; $display("FAIL x1_first: got %0d expected 8", car_x1); end end
      if (c == 12) begin checks++; if (car_x3 !== 10'd328) begin failures++; $display("FAIL x3_first: got %0d expected 328", car_x3); end end
      if (c == 16) begin checks++; if (car_x2 !== 10'd152) begin failures++; $display("FAIL x2_first: got %0d expected 152", car_x2); end end
      if (c == 20) begin checks++; if (car_x4 !== 10'd472) begin failures++; $display("FAIL x4_first: got %0d expected 472", car_x4); end end
      if (c == 7)  begin checks++; if (w_x1 !== 10'd632)   begin failures++; $display("FAIL wrap_x1_pre: got %0d expected 632", w_x1); end end
      if (c == 8)  begin checks++; if (w_x1 !== 10'd0)     begin failures++; $display("FAIL wrap_right: got %0d expected 0", w_x1); end end
      if (c == 16) begin checks++; if (w_x2 !== 10'd636)   begin failures++; $display("FAIL wrap_left: got %0d expected 636", w_x2); end end
    end
    start = 1'b0;
  endtask

  task automatic test_pause();
    do_reset();
    enter_run();
    repeat (4) tick();
    pause = 1'b1;
    tick();
    checks++;
    if (dbg_state !== PAUSED || running !== 1'b0) begin failures++; $display("FAIL pause_enter: got state %0d running %0b expected 2/0", dbg_state, running); end
    for (int c = 0; c < 99; c++) begin
      tick();
      checks++;
      if (car_x1 !== 10'd0 || dut_vec !== exp_vec()) begin failures++; $display("FAIL pause_hold c=%0d: got %h expected %h", c, dut_vec, exp_vec()); end
    end
    pause = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (car_x1 !== 10'd0) begin failures++; $display("FAIL pause_resume_early: got %0d expected 0", car_x1); end
    tick();
    checks++;
    if (car_x1 !== 10'd8 || dut_vec !== exp_vec()) begin failures++; $display("FAIL pause_resume: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_level();
    logic [9:0] x0;
    do_reset();
    enter_run();
    for (int k = 0; k < 4; k++) begin
      level_up = 1'b1;
      tick();
      level_up = 1'b0;
      checks++;
      if (level !== 2'((k + 1 > 3) ? 3 : k + 1)) begin failures++; $display("FAIL level_inc k=%0d: got %0d expected %0d", k, level, (k + 1 > 3) ? 3 : k + 1); end
      if (k < 3) tick();
    end
    x0 = car_x1;
    tick();
    checks++;
    if (car_x1 !== x0) begin failures++; $display("FAIL level_floor_hold: got %0d expected %0d", car_x1, x0); end
    tick();
    checks++;
    if (car_x1 !== 10'((x0 + 8) % 640)) begin failures++; $display("FAIL level_floor_move: got %0d expected %0d", car_x1, (x0 + 8) % 640); end
    tick(); tick();
    checks++;
    if (car_x1 !== 10'((x0 + 16) % 640) || dut_vec !== exp_vec()) begin failures++; $display("FAIL level_floor_move2: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_coincident();
    do_reset();
    enter_run();
    repeat (7) tick();
    level_up = 1'b1;
    tick();
    level_up = 1'b0;
    checks++;
    if (car_x1 !== 10'd0 || level !== 2'd1) begin failures++; $display("FAIL coincident_suppress: got x1=%0d level=%0d expected 0/1", car_x1, level); end
    repeat (3) tick();
    checks++;
    if (car_x1 !== 10'd0) begin failures++; $display("FAIL coincident_clear: got %0d expected 0", car_x1); end
    tick();
    checks++;
    if (car_x1 !== 10'd8 || dut_vec !== exp_vec()) begin failures++; $display("FAIL coincident_next: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    enter_run();
    repeat (30) tick();
    #3 RST = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({car_x1, car_x2, car_x3, car_x4, level, running} !== {10'd0, 10'd160, 10'd320, 10'd480, 2'd0, 1'b0} || dbg_state !== IDLE) begin
      failures++; $display("FAIL async_reset: got %h expected %h", dut_vec, exp_vec());
    end
    RST = 1'b0;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin failures++; $display("FAIL async_reset_idle: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_steady();
    logic [9:0] last, e;
    do_reset();
    exp_q.delete();
    for (int k = 1; k <= 90; k++) exp_q.push_back(10'((k * 8) % 640));
    enter_run();
    last = car_x1;
    for (int c = 1; c <= 720; c++) begin
      tick();
      if (car_x1 !== last) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        checks++;
        if (car_x1 !== e || (c % 8) != 0) begin failures++; $display("FAIL steady c=%0d: got %0d expected %0d", c, car_x1, e); end
        last = car_x1;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL steady_count: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 1; c <= 3000; c++) begin
      if (c % 300 == 0) do_reset();
      start    = ($urandom_range(0, 9) == 0);
      pause    = ($urandom_range(0, 5) == 0);
      level_up = ($urandom_range(0, 60) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("FAIL random c=%0d: got %h expected %h", c, dut_vec, exp_vec()); end
    end
    start = 1'b0; pause = 1'b0; level_up = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_pause();
    test_level();
    test_coincident();
    test_async_reset();
    test_steady();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
